// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: expands one load/store-multiple into per-register EX/MEM transfers.
// Optional LMSM_ADDR_WRAP_ERR_EN: abort with sticky err instead of wrapping past the top address.
module lm_sm_sequencer #(
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_is_lm,
    input  logic            in_is_sm,
    input  logic [NREG-1:0] in_mask,
    input  logic [AW-1:0]   in_base,
    input  logic [AW-1:0]   in_pc,
    input  logic            mem_ready,
    output logic            stall_EX,
    output logic            out_valid,
    output logic [AW-1:0]   out_M_addr,
    output logic [2:0]      out_RDest,
    output logic            out_W_reg,
    output logic            out_W_mem,
    output logic            out_mem_ans,
    output logic [1:0]      out_LMStart,
    output logic [AW-1:0]   out_pc,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [NREG-1:0] mask_q, mask_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   offset_q, offset_d;
    logic            is_lm_q, is_lm_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic            valid_q, valid_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      rdest_q, rdest_d;
    logic            w_reg_q, w_reg_d;
    logic            w_mem_q, w_mem_d;
    logic            mem_ans_q, mem_ans_d;
    logic [1:0]      lm_start_q, lm_start_d;

    logic            start, nop, last, wrap_abort;
    logic [2:0]      low_idx;

    always_comb begin
        start = in_valid & (in_is_lm ^ in_is_sm) & (in_mask != '0);
        nop   = in_valid & (in_is_lm ^ in_is_sm) & (in_mask == '0);
        // Only one bit left once clearing the lowest set bit empties the mask.
        last  = (mask_q & (mask_q - 1'b1)) == '0;
        low_idx = 3'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
`ifdef LMSM_ADDR_WRAP_ERR_EN
        wrap_abort = ({1'b0, base_q} + {1'b0, offset_q}) > {1'b0, {AW{1'b1}}};
`else
        wrap_abort = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        base_d     = base_q;
        pc_d       = pc_q;
        offset_d   = offset_q;
        is_lm_d    = is_lm_q;
        err_d      = err_q;
        done_d     = 1'b0;
        valid_d    = 1'b0;
        addr_d     = '0;
        rdest_d    = 3'd0;
        w_reg_d    = 1'b0;
        w_mem_d    = 1'b0;
        mem_ans_d  = 1'b0;
        lm_start_d = 2'b00;
        stall_EX   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    mask_d   = in_mask;
                    base_d   = in_base;
                    pc_d     = in_pc;
                    offset_d = '0;
                    is_lm_d  = in_is_lm;
                    stall_EX = 1'b1;
                end else if (nop) begin
                    done_d = 1'b1;
                end
            end
            StRun: begin
                stall_EX = 1'b1;
                if (mem_ready) begin
                    if (wrap_abort) begin
                        err_d    = 1'b1;
                        done_d   = 1'b1;
                        mask_d   = '0;
                        state_d  = StIdle;
                        stall_EX = 1'b0;
                    end else begin
                        valid_d    = 1'b1;
                        addr_d     = base_q + offset_q;
                        rdest_d    = low_idx;
                        w_reg_d    = is_lm_q;
                        w_mem_d    = ~is_lm_q;
                        mem_ans_d  = is_lm_q;
                        lm_start_d = last ? 2'b11 : (offset_q == '0) ? 2'b01 : 2'b10;
                        mask_d     = mask_q & (mask_q - 1'b1);
                        offset_d   = offset_q + 1'b1;
                        if (last) begin
                            state_d  = StIdle;
                            done_d   = 1'b1;
                            stall_EX = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (reset) stall_EX = 1'b0;
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            base_q     <= '0;
            pc_q       <= '0;
            offset_q   <= '0;
            is_lm_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            rdest_q    <= 3'd0;
            w_reg_q    <= 1'b0;
            w_mem_q    <= 1'b0;
            mem_ans_q  <= 1'b0;
            lm_start_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            base_q     <= base_d;
            pc_q       <= pc_d;
            offset_q   <= offset_d;
            is_lm_q    <= is_lm_d;
            err_q      <= err_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            rdest_q    <= rdest_d;
            w_reg_q    <= w_reg_d;
            w_mem_q    <= w_mem_d;
            mem_ans_q  <= mem_ans_d;
            lm_start_q <= lm_start_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_M_addr  = addr_q;
    assign out_RDest   = rdest_q;
    assign out_W_reg   = w_reg_q;
    assign out_W_mem   = w_mem_q;
    assign out_mem_ans = mem_ans_q;
    assign out_LMStart = lm_start_q;
    assign out_pc      = pc_q;
    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign err         = err_q;

endmodule
